snac_port_scanner: RTL and testbench

- Time-multiplexed reader for SNAC controllers on the MiSTer user port.
- Generalises the fixed two-player split scan to NUM_PORTS players, with a settle timer, input synchronisation, coherent per-frame output commit and port swap.
- Sits between USER_IN/USER_OUT/USER_MODE and the console core's joystick/paddle inputs, in the clk_sys domain.

---
 rtl/snac_pkg.sv | 34 +++
 rtl/snac_port_scanner_if.sv | 26 ++
 rtl/snac_sync2.sv | 26 ++
 rtl/snac_port_scanner.sv | 177 +++++++++++++++++
 tb/tb_snac_port_scanner.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/snac_pkg.sv
// Shared types and constants for the SNAC user-port scanner.
package snac_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_SAMPLE  = 2'd2,
        ST_ADVANCE = 2'd3
    } snac_state_t;

    localparam int BIT_R    = 2;
    localparam int BIT_L    = 1;
    localparam int BIT_D    = 7;
    localparam int BIT_U    = 5;
    localparam int BIT_F    = 3;
    localparam int BIT_PAD0 = 1;
    localparam int BIT_PAD1 = 2;

    localparam logic [2:0] USER_MODE_OFF  = 3'b000;
    localparam logic [2:0] USER_MODE_SNAC = 3'b100;

    localparam int JOY_W = 5;
    localparam int PAD_W = 2;

    // Controller lines are active-low; joystick fields are presented active-high.
    function automatic logic [JOY_W-1:0] snac_joy(input logic [7:0] s);
        return ~{s[BIT_F], s[BIT_U], s[BIT_D], s[BIT_L], s[BIT_R]};
    endfunction

    function automatic logic [PAD_W-1:0] snac_pad(input logic [7:0] s);
        return {s[BIT_PAD1], s[BIT_PAD0]};
    endfunction

endpackage

// File: rtl/snac_port_scanner_if.sv
// User-port and joystick bundle of the SNAC scanner; master = core/bench side, slave = scanner.
interface snac_port_scanner_if #(
    parameter int NUM_PORTS = 2
);
    import snac_pkg::*;

    logic                         enable;
    logic                         swap;
    logic [7:0]                   user_in;
    logic [7:0]                   user_out;
    logic [2:0]                   user_mode;
    logic [NUM_PORTS*JOY_W-1:0]   joy_out;
    logic [NUM_PORTS*PAD_W-1:0]   pad_out;
    logic                         frame_done;

    modport master (
        output enable, swap, user_in,
        input  user_out, user_mode, joy_out, pad_out, frame_done
    );

    modport slave (
        input  enable, swap, user_in,
        output user_out, user_mode, joy_out, pad_out, frame_done
    );

endinterface

// File: rtl/snac_sync2.sv
// Two-flop synchroniser; resets to all-ones so the lines read as released.
module snac_sync2 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_meta;
    logic [WIDTH-1:0] r_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_meta <= '1;
            r_sync <= '1;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/snac_port_scanner.sv
// Time-multiplexed SNAC reader: scans NUM_PORTS controllers and commits one coherent frame.
// Define SNAC_DEBOUNCE_EN for a 3-sample majority-vote capture per port.
module snac_port_scanner
    import snac_pkg::*;
#(
    parameter int NUM_PORTS     = 2,
    parameter int SETTLE_CYCLES = 64,
    parameter int SEL_LSB       = 4
) (
    input  logic                 clk_sys,
    input  logic                 reset,
    snac_port_scanner_if.slave   bus
);

    localparam int SEL_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int CNT_W = $clog2(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [SEL_W-1:0] LAST_PORT   = SEL_W'(NUM_PORTS - 1);
    localparam logic [2:0]       SCAN_MODE   = (NUM_PORTS > 1) ? USER_MODE_SNAC : USER_MODE_OFF;

    // A single controller needs no select code, so the lines stay released.
    function automatic logic [7:0] sel_word(input logic [SEL_W-1:0] port);
        logic [7:0] w;
        w = 8'hFF;
        if (NUM_PORTS > 1) w[SEL_LSB +: SEL_W] = port;
        return w;
    endfunction

    snac_state_t                  r_state;
    logic [SEL_W-1:0]             r_port;
    logic [CNT_W-1:0]             r_cnt;
    logic [NUM_PORTS*JOY_W-1:0]   r_shj;
    logic [NUM_PORTS*PAD_W-1:0]   r_shp;
    logic [NUM_PORTS*JOY_W-1:0]   r_joy;
    logic [NUM_PORTS*PAD_W-1:0]   r_pad;
    logic                         r_frame_done;
    logic [7:0]                   r_user_out;
    logic [2:0]                   r_user_mode;

    logic [7:0]                   w_sync;
    logic [7:0]                   w_cap;
    logic                         w_cap_last;
    logic [NUM_PORTS*JOY_W-1:0]   w_commit_joy;
    logic [NUM_PORTS*PAD_W-1:0]   w_commit_pad;

    snac_sync2 #(.WIDTH(8)) u_sync (
        .clk (clk_sys),
        .rst (reset),
        .i_d (bus.user_in),
        .o_q (w_sync)
    );

`ifdef SNAC_DEBOUNCE_EN
    logic [7:0] r_smp_a;
    logic [7:0] r_smp_b;
    logic [1:0] r_smp_idx;

    function automatic logic [7:0] maj3(input logic [7:0] a, input logic [7:0] b,
                                        input logic [7:0] c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    assign w_cap      = maj3(r_smp_a, r_smp_b, w_sync);
    assign w_cap_last = (r_smp_idx == 2'd2);

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_smp_a   <= '1;
            r_smp_b   <= '1;
            r_smp_idx <= '0;
        end else if (!bus.enable || r_state != ST_SAMPLE) begin
            r_smp_idx <= '0;
        end else begin
            if (r_smp_idx == 2'd0) r_smp_a <= w_sync;
            if (r_smp_idx == 2'd1) r_smp_b <= w_sync;
            r_smp_idx <= w_cap_last ? 2'd0 : r_smp_idx + 2'd1;
        end
    end
`else
    assign w_cap      = w_sync;
    assign w_cap_last = 1'b1;
`endif

    // Swap only ever exchanges ports 0 and 1; further ports pass straight through.
    generate
        if (NUM_PORTS >= 2) begin : g_swap
            always_comb begin
                w_commit_joy = r_shj;
                w_commit_pad = r_shp;
                if (bus.swap) begin
                    w_commit_joy[0     +: JOY_W] = r_shj[JOY_W +: JOY_W];
                    w_commit_joy[JOY_W +: JOY_W] = r_shj[0     +: JOY_W];
                    w_commit_pad[0     +: PAD_W] = r_shp[PAD_W +: PAD_W];
                    w_commit_pad[PAD_W +: PAD_W] = r_shp[0     +: PAD_W];
                end
            end
        end else begin : g_noswap
            assign w_commit_joy = r_shj;
            assign w_commit_pad = r_shp;
        end
    endgenerate

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_port       <= '0;
            r_cnt        <= '0;
            r_shj        <= '0;
            r_shp        <= '0;
            r_joy        <= '0;
            r_pad        <= '0;
            r_frame_done <= 1'b0;
            r_user_out   <= 8'hFF;
            r_user_mode  <= USER_MODE_OFF;
        end else if (!bus.enable) begin
            // Dropping enable abandons the frame in progress and blanks the outputs.
            r_state      <= ST_IDLE;
            r_port       <= '0;
            r_cnt        <= '0;
            r_shj        <= '0;
            r_shp        <= '0;
            r_joy        <= '0;
            r_pad        <= '0;
            r_frame_done <= 1'b0;
            r_user_out   <= 8'hFF;
            r_user_mode  <= USER_MODE_OFF;
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_port      <= '0;
                    r_cnt       <= SETTLE_LOAD;
                    r_state     <= ST_SETTLE;
                    r_user_out  <= sel_word('0);
                    r_user_mode <= SCAN_MODE;
                end
                ST_SETTLE: begin
                    if (r_cnt == '0) r_state <= ST_SAMPLE;
                    else             r_cnt   <= r_cnt - 1'b1;
                end
                ST_SAMPLE: begin
                    if (w_cap_last) begin
                        for (int p = 0; p < NUM_PORTS; p++) begin
                            if (r_port == SEL_W'(p)) begin
                                r_shj[p*JOY_W +: JOY_W] <= snac_joy(w_cap);
                                r_shp[p*PAD_W +: PAD_W] <= snac_pad(w_cap);
                            end
                        end
                        r_state <= ST_ADVANCE;
                    end
                end
                ST_ADVANCE: begin
                    r_cnt   <= SETTLE_LOAD;
                    r_state <= ST_SETTLE;
                    if (r_port == LAST_PORT) begin
                        r_port       <= '0;
                        r_joy        <= w_commit_joy;
                        r_pad        <= w_commit_pad;
                        r_frame_done <= 1'b1;
                        r_user_out   <= sel_word('0);
                    end else begin
                        r_port     <= r_port + 1'b1;
                        r_user_out <= sel_word(r_port + 1'b1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.user_out   = r_user_out;
    assign bus.user_mode  = r_user_mode;
    assign bus.joy_out    = r_joy;
    assign bus.pad_out    = r_pad;
    assign bus.frame_done = r_frame_done;

endmodule

// File: tb/tb_snac_port_scanner.sv
// Bench for snac_port_scanner: a 2-port/8-settle and a 4-port/3-settle instance driven by controller models.
module tb_snac_port_scanner;
    import snac_pkg::*;

`ifdef SNAC_DEBOUNCE_EN
    localparam int SMP = 3;
`else
    localparam int SMP = 1;
`endif
    localparam int S2   = 8;
    localparam int S4   = 3;
    localparam int PER2 = 2 * (S2 + SMP + 1);
    localparam int PER4 = 4 * (S4 + SMP + 1);

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    snac_port_scanner_if #(.NUM_PORTS(2)) bus2 ();
    snac_port_scanner_if #(.NUM_PORTS(4)) bus4 ();

    snac_port_scanner #(.NUM_PORTS(2), .SETTLE_CYCLES(S2), .SEL_LSB(4)) dut2 (
        .clk_sys (clk),
        .reset   (rst),
        .bus     (bus2.slave)
    );

    snac_port_scanner #(.NUM_PORTS(4), .SETTLE_CYCLES(S4), .SEL_LSB(4)) dut4 (
        .clk_sys (clk),
        .reset   (rst),
        .bus     (bus4.slave)
    );

    // Controller models: each answers with the pattern of the port currently selected.
    logic [3:0][7:0] pat2;
    logic [3:0][7:0] pat4;
    logic            glitch;

    always_comb begin
        bus2.user_in = pat2[{1'b0, bus2.user_out[4]}];
        if (glitch && !bus2.user_out[4]) bus2.user_in[BIT_R] = 1'b0;
        bus4.user_in = pat4[bus4.user_out[5:4]];
    end

    typedef struct {
        int              dut;
        logic [3:0][7:0] pat;
        logic            swap;
        logic [19:0]     joy;
        logic [7:0]      pad;
    } vec_t;

    typedef struct {
        int          dut;
        logic [19:0] joy;
        logic [7:0]  pad;
    } exp_t;

    vec_t vt[7];
    exp_t sb_q[$];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic wait_fd(input int k, input int budget, output int cycles, output bit ok);
        ok     = 1'b0;
        cycles = 0;
        for (int i = 1; i <= budget; i++) begin
            @(negedge clk);
            if ((k == 2 ? bus2.frame_done : bus4.frame_done) === 1'b1) begin
                ok     = 1'b1;
                cycles = i;
                break;
            end
        end
    endtask

    int  cyc;
    bit  ok;
    int  pulses;
    int  bad_idle;
    int  seq[8];
    int  seq_n;
    int  last_sel;
    int  cur_sel;
    exp_t e;

    initial begin
        vt[0] = '{2, {8'hFF, 8'hFF, 8'hF7, 8'hFB}, 1'b0, 20'h00201, 8'h0D};
        vt[1] = '{2, {8'hFF, 8'hFF, 8'hF7, 8'hFB}, 1'b1, 20'h00030, 8'h07};
        vt[2] = '{2, {8'hFF, 8'hFF, 8'hFF, 8'h5D}, 1'b0, 20'h0000E, 8'h0E};
        vt[3] = '{2, {8'hFF, 8'hFF, 8'hDF, 8'h00}, 1'b0, 20'h0011F, 8'h0C};
        vt[4] = '{2, {8'hFF, 8'hFF, 8'hDF, 8'h00}, 1'b1, 20'h003E8, 8'h03};
        vt[5] = '{4, {8'hDF, 8'h5D, 8'hF7, 8'hFB}, 1'b0, 20'h43A01, 8'hED};
        vt[6] = '{4, {8'hDF, 8'h5D, 8'hF7, 8'hFB}, 1'b1, 20'h43830, 8'hE7};

        rst          = 1'b1;
        glitch       = 1'b0;
        pat2         = {4{8'hFF}};
        pat4         = {4{8'hFF}};
        bus2.enable  = 1'b0;
        bus2.swap    = 1'b0;
        bus4.enable  = 1'b0;
        bus4.swap    = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset then idle with enable low
        @(negedge clk);
        check("rst_user_out2", 32'(bus2.user_out), 32'hFF);
        check("rst_user_mode2", 32'(bus2.user_mode), 32'h0);
        check("rst_joy2", 32'(bus2.joy_out), 32'h0);
        check("rst_pad2", 32'(bus2.pad_out), 32'h0);
        check("rst_joy4", 32'(bus4.joy_out), 32'h0);
        pulses   = 0;
        bad_idle = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (bus2.frame_done || bus4.frame_done) pulses++;
            if (bus2.user_out !== 8'hFF || bus4.user_out !== 8'hFF) bad_idle++;
        end
        check("idle_frame_done", 32'(pulses), 32'h0);
        check("idle_user_out", 32'(bad_idle), 32'h0);

        bus2.enable = 1'b1;
        bus4.enable = 1'b1;

        // Table-driven frames through the scoreboard
        for (int v = 0; v < 7; v++) begin
            if (vt[v].dut == 2) begin
                pat2      = vt[v].pat;
                bus2.swap = vt[v].swap;
            end else begin
                pat4      = vt[v].pat;
                bus4.swap = vt[v].swap;
            end
            sb_q.push_back('{vt[v].dut, vt[v].joy, vt[v].pad});
            wait_fd(vt[v].dut, 3 * PER2 + 3 * PER4, cyc, ok);
            check($sformatf("fd_flush_v%0d", v), 32'(ok), 32'h1);
            wait_fd(vt[v].dut, 2 * PER2 + 2 * PER4, cyc, ok);
            check($sformatf("fd_seen_v%0d", v), 32'(ok), 32'h1);
            check($sformatf("period_v%0d", v), 32'(cyc), 32'(vt[v].dut == 2 ? PER2 : PER4));
            e = sb_q.pop_front();
            if (e.dut == 2) begin
                check($sformatf("joy_v%0d", v), 32'(bus2.joy_out), 32'(e.joy));
                check($sformatf("pad_v%0d", v), 32'(bus2.pad_out), 32'(e.pad));
                check($sformatf("mode_v%0d", v), 32'(bus2.user_mode), 32'(USER_MODE_SNAC));
            end else begin
                check($sformatf("joy_v%0d", v), 32'(bus4.joy_out), 32'(e.joy));
                check($sformatf("pad_v%0d", v), 32'(bus4.pad_out), 32'(e.pad));
                check($sformatf("mode_v%0d", v), 32'(bus4.user_mode), 32'(USER_MODE_SNAC));
            end
        end

        // Four-port select sequence over one frame
        wait_fd(4, 2 * PER4, cyc, ok);
        check("fd_seen_sel4", 32'(ok), 32'h1);
        seq_n    = 0;
        last_sel = -1;
        bad_idle = 0;
        for (int k = 0; k < PER4; k++) begin
            if (k > 0) @(negedge clk);
            cur_sel = int'(bus4.user_out[5:4]);
            if ((bus4.user_out | 8'h30) !== 8'hFF) bad_idle++;
            if (cur_sel != last_sel) begin
                if (seq_n < 8) seq[seq_n] = cur_sel;
                seq_n++;
                last_sel = cur_sel;
            end
        end
        check("sel4_count", 32'(seq_n), 32'h4);
        check("sel4_other_bits", 32'(bad_idle), 32'h0);
        for (int i = 0; i < 4; i++) check($sformatf("sel4_order%0d", i), 32'(seq[i]), 32'(i));

        // Enable dropped five cycles into port 1's settle
        pat2      = vt[0].pat;
        bus2.swap = 1'b0;
        wait_fd(2, 2 * PER2, cyc, ok);
        check("fd_seen_drop", 32'(ok), 32'h1);
        repeat (S2 + SMP + 1 + 5) @(posedge clk);
        #1;
        check("drop_sel_port1", 32'(bus2.user_out[4]), 32'h1);
        bus2.enable = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("drop_user_out", 32'(bus2.user_out), 32'hFF);
        check("drop_user_mode", 32'(bus2.user_mode), 32'h0);
        check("drop_joy", 32'(bus2.joy_out), 32'h0);
        check("drop_pad", 32'(bus2.pad_out), 32'h0);
        pulses = 0;
        for (int i = 0; i < 2 * PER2; i++) begin
            @(negedge clk);
            if (bus2.frame_done) pulses++;
        end
        check("drop_no_fd", 32'(pulses), 32'h0);

        // Re-enable: full-length first frame with valid data
        bus2.enable = 1'b1;
        wait_fd(2, 3 * PER2, cyc, ok);
        check("fd_seen_reen", 32'(ok), 32'h1);
        check("reen_latency", 32'(cyc), 32'(PER2 + 1));
        check("reen_joy", 32'(bus2.joy_out), 32'h201);

`ifdef SNAC_DEBOUNCE_EN
        // One low sample out of three is voted away
        pat2 = {4{8'hFF}};
        wait_fd(2, 2 * PER2, cyc, ok);
        wait_fd(2, 2 * PER2, cyc, ok);
        check("fd_seen_db1", 32'(ok), 32'h1);
        repeat (6) @(posedge clk);
        #1 glitch = 1'b1;
        @(posedge clk);
        #1 glitch = 1'b0;
        wait_fd(2, 2 * PER2, cyc, ok);
        check("db1_joy", 32'(bus2.joy_out), 32'h0);
        check("db1_pad", 32'(bus2.pad_out), 32'hF);

        // Two low samples out of three win
        repeat (6) @(posedge clk);
        #1 glitch = 1'b1;
        repeat (2) @(posedge clk);
        #1 glitch = 1'b0;
        wait_fd(2, 2 * PER2, cyc, ok);
        check("db2_joy", 32'(bus2.joy_out), 32'h1);
        check("db2_pad", 32'(bus2.pad_out), 32'hD);
`endif

        // Asynchronous reset mid-scan takes effect before the next clock edge
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_user_out", 32'(bus2.user_out), 32'hFF);
        check("arst_user_mode", 32'(bus2.user_mode), 32'h0);
        check("arst_joy", 32'(bus2.joy_out), 32'h0);
        check("arst_joy4", 32'(bus4.joy_out), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
